// File: rtl/led_cmd_ctrl.sv
// LED waterfall command controller: decodes 2-byte UART frames into mode/speed/pattern
// updates and returns one ACK/NAK byte per frame. Define LED_CMD_READBACK_EN to enable STATUS (0x04).
module led_cmd_ctrl #(
    parameter int                 LED_NUM     = 4,
    parameter logic [LED_NUM-1:0] INIT_STA    = 4'b1100,
    parameter int                 DIV_UNIT    = 100000,
    parameter int                 INIT_SPD    = 24,
    parameter int                 TIMEOUT_CYC = 2500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         ack_data,
    output logic               ack_valid,
    input  logic               ack_ready,
    output logic [LED_NUM-1:0] led_sig,
    output logic [1:0]         mode
);

    // state    | meaning
    // IDLE     | waiting for a header (opcode) byte
    // WAIT_ARG | opcode latched, waiting for the argument byte or timeout
    typedef enum logic [0:0] {IDLE, WAIT_ARG} state_t;

    localparam logic [7:0]  ACK      = 8'h06;
    localparam logic [7:0]  NAK      = 8'h15;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

    state_t             state;
    logic [7:0]         opcode;
    logic [7:0]         spd;
    logic [31:0]        tmo;
    logic [31:0]        cnt;
    logic [31:0]        div;
    logic [LED_NUM-1:0] pat;
    logic               phase;
    logic               exec;
    logic               cmd_hit;
    logic               step;
    logic [7:0]         resp;

    assign led_sig = phase ? '0 : pat;

    always_comb begin
        div     = (32'(spd) + 32'd1) * 32'(DIV_UNIT) - 32'd1;
        step    = (cnt == div);
        exec    = (state == WAIT_ARG) && rx_valid;
        cmd_hit = 1'b0;
        resp    = NAK;
        case (opcode)
            8'h01, 8'h02, 8'h03: begin
                cmd_hit = exec;
                resp    = ACK;
            end
`ifdef LED_CMD_READBACK_EN
            8'h04: resp = {mode, 2'b00, 4'(led_sig)};
`endif
            default: resp = NAK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            opcode    <= 8'h00;
            tmo       <= 32'd0;
            spd       <= 8'(INIT_SPD);
            cnt       <= 32'd0;
            pat       <= INIT_STA;
            phase     <= 1'b0;
            mode      <= 2'd2;
            ack_valid <= 1'b0;
            ack_data  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        opcode <= rx_data;
                        tmo    <= 32'd0;
                        state  <= WAIT_ARG;
                    end
                end
                WAIT_ARG: begin
                    if (rx_valid || tmo == TMO_LAST) begin
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A new response always wins over a pending one, even if it is being accepted.
            if (exec) begin
                ack_data  <= resp;
                ack_valid <= 1'b1;
            end else if (ack_ready) begin
                ack_valid <= 1'b0;
            end

            if (cmd_hit && opcode != 8'h01) begin
                cnt <= 32'd0;
            end else if (step) begin
                cnt <= 32'd0;
            end else begin
                cnt <= cnt + 32'd1;
            end

            // A configuration frame takes priority over a coincident step.
            if (cmd_hit) begin
                case (opcode)
                    8'h01: begin
                        mode  <= rx_data[1:0];
                        phase <= 1'b0;
                    end
                    8'h02: spd <= rx_data;
                    default: begin
                        pat   <= rx_data[LED_NUM-1:0];
                        phase <= 1'b0;
                    end
                endcase
            end else if (step) begin
                case (mode)
                    2'd1:    pat   <= {pat[LED_NUM-2:0], pat[LED_NUM-1]};
                    2'd2:    pat   <= {pat[0], pat[LED_NUM-1:1]};
                    2'd3:    phase <= ~phase;
                    default: pat   <= pat;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Directed self-checking bench for led_cmd_ctrl with a 4-cycle step period and 16-cycle timeout.
module tb_led_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       ack_ready = 1'b1;
    logic [7:0] ack_data;
    logic       ack_valid;
    logic [3:0] led_sig;
    logic [1:0] mode;

    int total = 0;
    int bad = 0;

    led_cmd_ctrl #(
        .LED_NUM(4), .INIT_STA(4'b1100), .DIV_UNIT(2), .INIT_SPD(1), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .ack_data(ack_data), .ack_valid(ack_valid), .ack_ready(ack_ready),
        .led_sig(led_sig), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        // reset values
        tick(2);
        chk("rst_led", 32'(led_sig), 32'hC);
        chk("rst_mode", 32'(mode), 32'd2);
        chk("rst_ack_valid", 32'(ack_valid), 32'd0);
        chk("rst_ack_data", 32'(ack_data), 32'h00);
        rst = 1'b0;

        // free-running rotate right, one step per 4 cycles
        tick(3);
        chk("rr_pre", 32'(led_sig), 32'hC);
        tick(1);
        chk("rr_1", 32'(led_sig), 32'h6);
        tick(4);
        chk("rr_2", 32'(led_sig), 32'h3);
        tick(4);
        chk("rr_3", 32'(led_sig), 32'h9);
        tick(2);
        rst = 1'b1;
        #1;
        chk("async_rst_led", 32'(led_sig), 32'hC);
        chk("async_rst_mode", 32'(mode), 32'd2);
        tick(1);
        rst = 1'b0;
        tick(3);
        chk("cnt_cleared_pre", 32'(led_sig), 32'hC);
        tick(1);
        chk("cnt_cleared_step", 32'(led_sig), 32'h6);

        // LOAD 0x05 then SET_MODE left
        do_reset();
        ack_ready = 1'b1;
        send(8'h03);
        send(8'h05);
        chk("load_led", 32'(led_sig), 32'h5);
        chk("load_ack_valid", 32'(ack_valid), 32'd1);
        chk("load_ack_data", 32'(ack_data), 32'h06);
        send(8'h01);
        chk("load_ack_1cyc", 32'(ack_valid), 32'd0);
        send(8'h01);
        chk("mode_left", 32'(mode), 32'd1);
        chk("mode_ack_valid", 32'(ack_valid), 32'd1);
        chk("mode_ack_data", 32'(ack_data), 32'h06);
        tick(1);
        chk("mode_ack_1cyc", 32'(ack_valid), 32'd0);
        chk("left_pre", 32'(led_sig), 32'h5);
        tick(1);
        chk("left_step", 32'(led_sig), 32'hA);

        // SET_SPEED 0: step every 2 cycles
        send(8'h02);
        send(8'h00);
        chk("spd0_ack", 32'(ack_data), 32'h06);
        chk("spd0_led", 32'(led_sig), 32'hA);
        tick(1);
        chk("spd0_e9", 32'(led_sig), 32'hA);
        tick(1);
        chk("spd0_e10", 32'(led_sig), 32'h5);
        tick(1);
        chk("spd0_e11", 32'(led_sig), 32'h5);
        tick(1);
        chk("spd0_e12", 32'(led_sig), 32'hA);

        // SET_SPEED 255 collides with a step: frame wins, next step 512 cycles later
        send(8'h02);
        send(8'hFF);
        chk("collision_drop", 32'(led_sig), 32'hA);
        tick(511);
        chk("spd255_pre", 32'(led_sig), 32'hA);
        tick(1);
        chk("spd255_step", 32'(led_sig), 32'h5);

        // unknown opcode: NAK, nothing changes
        send(8'h7E);
        send(8'h00);
        chk("nak_data", 32'(ack_data), 32'h15);
        chk("nak_valid", 32'(ack_valid), 32'd1);
        chk("nak_mode", 32'(mode), 32'd1);
        chk("nak_led", 32'(led_sig), 32'h5);
        tick(509);
        chk("nak_spd_pre", 32'(led_sig), 32'h5);
        tick(1);
        chk("nak_spd_step", 32'(led_sig), 32'hA);

        // header then timeout: frame discarded, next frame parses cleanly
        send(8'h01);
        tick(20);
        chk("tmo_no_resp", 32'(ack_valid), 32'd0);
        send(8'h02);
        chk("tmo_hdr_only", 32'(ack_valid), 32'd0);
        chk("tmo_mode_kept", 32'(mode), 32'd1);
        send(8'h00);
        chk("tmo_ack_valid", 32'(ack_valid), 32'd1);
        chk("tmo_ack_data", 32'(ack_data), 32'h06);
        tick(1);
        chk("tmo_spd0_pre", 32'(led_sig), 32'hA);
        tick(1);
        chk("tmo_spd0_step", 32'(led_sig), 32'h5);

        // backpressure: latest response wins, held until ack_ready
        ack_ready = 1'b0;
        send(8'h01);
        send(8'h00);
        chk("bp_mode_hold", 32'(mode), 32'd0);
        chk("bp_ack1", 32'(ack_data), 32'h06);
        send(8'h55);
        send(8'h00);
        chk("bp_nak_over", 32'(ack_data), 32'h15);
        send(8'h03);
        send(8'h09);
        chk("bp_ack_over", 32'(ack_data), 32'h06);
        chk("bp_led", 32'(led_sig), 32'h9);
        tick(3);
        chk("bp_still_valid", 32'(ack_valid), 32'd1);
        chk("bp_still_data", 32'(ack_data), 32'h06);
        chk("bp_hold_led", 32'(led_sig), 32'h9);
        ack_ready = 1'b1;
        tick(1);
        chk("bp_released", 32'(ack_valid), 32'd0);

        // blink alternates pattern and zero
        do_reset();
        send(8'h01);
        send(8'h03);
        chk("blink_mode", 32'(mode), 32'd3);
        chk("blink_e2", 32'(led_sig), 32'hC);
        tick(1);
        chk("blink_e3", 32'(led_sig), 32'hC);
        tick(1);
        chk("blink_off", 32'(led_sig), 32'h0);
        tick(3);
        chk("blink_off_hold", 32'(led_sig), 32'h0);
        tick(1);
        chk("blink_on", 32'(led_sig), 32'hC);

        // STATUS opcode
        do_reset();
        send(8'h04);
        send(8'h00);
        chk("status_valid", 32'(ack_valid), 32'd1);
`ifdef LED_CMD_READBACK_EN
        chk("status_data", 32'(ack_data), 32'h8C);
`else
        chk("status_nak", 32'(ack_data), 32'h15);
`endif
        chk("status_mode", 32'(mode), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
